arb_rr_n: RTL and testbench

ARB_RR_N -- requirements
Module: arb_rr_n

---
 rtl/arb_rr_n.sv | 100 ++++++++++
 tb/tb_arb_rr_n.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr_n.sv
// Round-robin arbiter over N requesters with registered one-hot grant and optional hold-time limit.
// A grant holder is pre-empted after MAX_HOLD cycles only when someone else is waiting.
module arb_rr_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit           HOLD_EN   = (MAX_HOLD > 0);
  localparam logic [7:0]   HOLD_LAST = (MAX_HOLD > 0) ? 8'(MAX_HOLD - 1) : 8'd0;
  localparam logic [N-1:0] ONE       = N'(1);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [7:0]     cnt;

  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic           any;
  logic           others;

  // First requester after ptr, wrapping; ptr itself is checked last.
  always_comb begin
    win  = ptr;
    cand = ptr;
    any  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = IDW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

  // In GRANT ptr is the holder, so a winner other than ptr means someone else is waiting.
  assign others = any && (win != ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_id  <= '0;
      timeout <= 1'b0;
      cnt     <= 8'd0;
      ptr     <= IDW'(N - 1);
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            state   <= GRANT;
            gnt     <= ONE << win;
            gnt_vld <= 1'b1;
            gnt_id  <= win;
            ptr     <= win;
            cnt     <= 8'd0;
          end
        end
        GRANT: begin
          if (req[ptr]) begin
            if (HOLD_EN && (cnt == HOLD_LAST) && others) begin
              gnt     <= ONE << win;
              gnt_id  <= win;
              ptr     <= win;
              cnt     <= 8'd0;
              timeout <= 1'b1;
            end else if (HOLD_EN && (cnt != HOLD_LAST)) begin
              cnt <= cnt + 8'd1;
            end
          end else if (any) begin
            gnt    <= ONE << win;
            gnt_id <= win;
            ptr    <= win;
            cnt    <= 8'd0;
          end else begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_id  <= '0;
            cnt     <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_n.sv
// Directed bench for arb_rr_n (N=4, MAX_HOLD=8): rotation, hold, timeout, release, reset, random invariants.
module tb_arb_rr_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arb_rr_n #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .timeout (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b0000;
    #1 rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++;
    if (gnt_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", gnt_vld); end
    checks++;
    if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", gnt_id); end
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] rv [5];
    logic [3:0] ev [5];
    logic [1:0] iv [5];
    rv = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    ev = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    iv = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      req = rv[i];
      tick();
      checks++;
      if (gnt !== ev[i] || gnt_id !== iv[i] || gnt_vld !== 1'b1) begin
        failures++;
        $display("FAIL wrap_step%0d gnt=%b id=%0d vld=%b exp gnt=%b id=%0d vld=1", i, gnt, gnt_id, gnt_vld, ev[i], iv[i]);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      failures++; $display("FAIL wrap_idle gnt=%b vld=%b exp gnt=0000 vld=0", gnt, gnt_vld);
    end
  endtask

  task automatic test_hold();
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || timeout !== 1'b0) begin
        failures++; $display("FAIL hold_cyc%0d gnt=%b timeout=%b exp gnt=0100 timeout=0", i, gnt, timeout);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      failures++; $display("FAIL hold_drop gnt=%b vld=%b exp gnt=0000 vld=0", gnt, gnt_vld);
    end
  endtask

  task automatic test_saturate();
    req = 4'b0100;
    repeat (12) tick();
    checks++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin
      failures++; $display("FAIL sat_hold gnt=%b timeout=%b exp gnt=0100 timeout=0", gnt, timeout);
    end
    req = 4'b0101;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || timeout !== 1'b1) begin
      failures++; $display("FAIL sat_rotate gnt=%b id=%0d timeout=%b exp gnt=0001 id=0 timeout=1", gnt, gnt_id, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || timeout !== 1'b0) begin
      failures++; $display("FAIL sat_pulse gnt=%b timeout=%b exp gnt=0001 timeout=0", gnt, timeout);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    req = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (gnt !== 4'b0001 || timeout !== 1'b0) begin
        failures++; $display("FAIL to_hold%0d gnt=%b timeout=%b exp gnt=0001 timeout=0", e, gnt, timeout);
      end
      if (e == 2) req = 4'b0101;
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || timeout !== 1'b1) begin
      failures++; $display("FAIL to_fire gnt=%b id=%0d timeout=%b exp gnt=0100 id=2 timeout=1", gnt, gnt_id, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin
      failures++; $display("FAIL to_onepulse gnt=%b timeout=%b exp gnt=0100 timeout=0", gnt, timeout);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || timeout !== 1'b0) begin
      failures++; $display("FAIL to_regain gnt=%b timeout=%b exp gnt=0001 timeout=0", gnt, timeout);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_release_at_limit();
    req = 4'b1010;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (gnt !== 4'b0010 || timeout !== 1'b0) begin
        failures++; $display("FAIL rel_hold%0d gnt=%b timeout=%b exp gnt=0010 timeout=0", e, gnt, timeout);
      end
    end
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || timeout !== 1'b0) begin
      failures++; $display("FAIL rel_limit gnt=%b id=%0d timeout=%b exp gnt=1000 id=3 timeout=0", gnt, gnt_id, timeout);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin failures++; $display("FAIL rstmid_pre gnt=%b exp=0010", gnt); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      failures++; $display("FAIL rstmid_async gnt=%b vld=%b exp gnt=0000 vld=0", gnt, gnt_vld);
    end
    req = 4'b1010;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      failures++; $display("FAIL rstmid_restart gnt=%b id=%0d exp gnt=0010 id=1", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    int waitc [4];
    int maxw = 0;
    int touts = 0;
    logic ok;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          req[i] = ($urandom_range(1) == 1);
        end
      end
      tick();
      ok = $onehot0(gnt) && (gnt_vld == (|gnt)) &&
           (gnt_vld ? gnt[gnt_id] : (gnt_id == 2'd0)) && (!timeout || gnt_vld);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand_inv cyc%0d gnt=%b vld=%b id=%0d timeout=%b", c, gnt, gnt_vld, gnt_id, timeout);
      end
      if (timeout) touts++;
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !gnt[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > maxw) maxw = waitc[i];
      end
    end
    checks++;
    if (maxw > 28) begin failures++; $display("FAIL rand_wait max=%0d limit=28", maxw); end
    checks++;
    if (touts == 0) begin failures++; $display("FAIL rand_timeouts seen=%0d exp>0", touts); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_hold();
    test_saturate();
    test_timeout();
    test_release_at_limit();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
